// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS-32 control FSM: sequences each instruction through a shared ALU
// and a unified memory, with memory states stalling on a handshake or a fixed latency.
module mips_multicycle_control #(
    parameter bit          MEM_HANDSHAKE = 1'b1,
    parameter int unsigned MEM_LATENCY   = 1,
    parameter bit          ENABLE_ADDI   = 1'b1,
    parameter bit          ENABLE_JUMP   = 1'b1
) (
    input  logic       globalclock,
    input  logic       globalreset,
    input  logic [5:0] opcode,
    input  logic       is_zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [3:0] state
);

    localparam int unsigned CNT_W = $clog2(MEM_LATENCY + 1);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   wait_cnt_q;
    logic               illegal_q;
    logic               illegal_set;
    logic               is_store_q;
    logic               in_mem;
    logic               done;

    // Completion of the current memory state; never asserted outside one.
    always_comb begin
        in_mem = (state_q == S_FETCH) || (state_q == S_MEM_READ) || (state_q == S_MEM_WRITE);
        if (MEM_HANDSHAKE) begin
            done = in_mem && mem_ready;
        end else begin
            done = in_mem && (wait_cnt_q == CNT_W'(MEM_LATENCY - 1));
        end
    end

    // lw/sw is remembered at DECODE because opcode is only valid there.
    always_ff @(posedge globalclock) begin
        if (globalreset) begin
            state_q    <= S_FETCH;
            wait_cnt_q <= '0;
            illegal_q  <= 1'b0;
            is_store_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (!in_mem || done) begin
                wait_cnt_q <= '0;
            end else begin
                wait_cnt_q <= wait_cnt_q + CNT_W'(1);
            end
            if (illegal_set) begin
                illegal_q <= 1'b1;
            end
            if (state_q == S_DECODE) begin
                is_store_q <= (opcode == OP_SW);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        illegal_set = 1'b0;
        pc_write    = 1'b0;
        i_or_d      = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        reg_write   = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        alu_op      = 2'b00;
        pc_source   = 2'b00;
        instr_done  = 1'b0;
        illegal_op  = illegal_q;
        state       = state_q;

        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = done;
                pc_write  = done;
                if (done) state_d = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_RTYPE:     state_d = S_R_EXEC;
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J: begin
                        state_d     = ENABLE_JUMP ? S_JUMP : S_FETCH;
                        illegal_set = !ENABLE_JUMP;
                    end
                    OP_ADDI: begin
                        state_d     = ENABLE_ADDI ? S_ADDI_EXEC : S_FETCH;
                        illegal_set = !ENABLE_ADDI;
                    end
                    default: begin
                        state_d     = S_FETCH;
                        illegal_set = 1'b1;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = is_store_q ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (done) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WRITE: begin
                mem_write  = 1'b1;
                i_or_d     = 1'b1;
                instr_done = done;
                if (done) state_d = S_FETCH;
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                state_d   = S_R_WB;
            end
            S_R_WB: begin
                reg_dst    = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_op     = 2'b01;
                pc_source  = 2'b01;
                pc_write   = is_zero;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_JUMP: begin
                pc_source  = 2'b10;
                pc_write   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_ADDI_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        // Reset kills every strobe immediately, including an in-flight write.
        if (globalreset) begin
            pc_write   = 1'b0;
            i_or_d     = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            ir_write   = 1'b0;
            reg_dst    = 1'b0;
            mem_to_reg = 1'b0;
            reg_write  = 1'b0;
            alu_src_a  = 1'b0;
            alu_src_b  = 2'b00;
            alu_op     = 2'b00;
            pc_source  = 2'b00;
            instr_done = 1'b0;
            illegal_op = 1'b0;
            state      = 4'd0;
        end
    end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for mips_multicycle_control: three configurations (fixed latency 1,
// handshake, fixed latency 3 with jump disabled) checked cycle by cycle.
module tb_mips_multicycle_control;

    typedef struct packed {
        logic       pc_write;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
        logic       illegal_op;
        logic [3:0] state;
    } ctl_t;

    logic       clk;
    logic       rst;
    logic [5:0] opcode;
    logic       is_zero;
    logic       mem_ready;
    ctl_t       c0;
    ctl_t       c1;
    ctl_t       c2;
    int         tests;
    int         errors;

    mips_multicycle_control #(.MEM_HANDSHAKE(1'b0), .MEM_LATENCY(1), .ENABLE_ADDI(1'b1), .ENABLE_JUMP(1'b1)) u_lat1 (
        .globalclock(clk), .globalreset(rst), .opcode(opcode), .is_zero(is_zero), .mem_ready(mem_ready),
        .pc_write(c0.pc_write), .i_or_d(c0.i_or_d), .mem_read(c0.mem_read), .mem_write(c0.mem_write),
        .ir_write(c0.ir_write), .reg_dst(c0.reg_dst), .mem_to_reg(c0.mem_to_reg), .reg_write(c0.reg_write),
        .alu_src_a(c0.alu_src_a), .alu_src_b(c0.alu_src_b), .alu_op(c0.alu_op), .pc_source(c0.pc_source),
        .instr_done(c0.instr_done), .illegal_op(c0.illegal_op), .state(c0.state)
    );

    mips_multicycle_control #(.MEM_HANDSHAKE(1'b1), .MEM_LATENCY(1), .ENABLE_ADDI(1'b1), .ENABLE_JUMP(1'b1)) u_hs (
        .globalclock(clk), .globalreset(rst), .opcode(opcode), .is_zero(is_zero), .mem_ready(mem_ready),
        .pc_write(c1.pc_write), .i_or_d(c1.i_or_d), .mem_read(c1.mem_read), .mem_write(c1.mem_write),
        .ir_write(c1.ir_write), .reg_dst(c1.reg_dst), .mem_to_reg(c1.mem_to_reg), .reg_write(c1.reg_write),
        .alu_src_a(c1.alu_src_a), .alu_src_b(c1.alu_src_b), .alu_op(c1.alu_op), .pc_source(c1.pc_source),
        .instr_done(c1.instr_done), .illegal_op(c1.illegal_op), .state(c1.state)
    );

    mips_multicycle_control #(.MEM_HANDSHAKE(1'b0), .MEM_LATENCY(3), .ENABLE_ADDI(1'b1), .ENABLE_JUMP(1'b0)) u_lat3 (
        .globalclock(clk), .globalreset(rst), .opcode(opcode), .is_zero(is_zero), .mem_ready(mem_ready),
        .pc_write(c2.pc_write), .i_or_d(c2.i_or_d), .mem_read(c2.mem_read), .mem_write(c2.mem_write),
        .ir_write(c2.ir_write), .reg_dst(c2.reg_dst), .mem_to_reg(c2.mem_to_reg), .reg_write(c2.reg_write),
        .alu_src_a(c2.alu_src_a), .alu_src_b(c2.alu_src_b), .alu_op(c2.alu_op), .pc_source(c2.pc_source),
        .instr_done(c2.instr_done), .illegal_op(c2.illegal_op), .state(c2.state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected control word for a state, written out from the state table by hand.
    function automatic ctl_t exp_ctl(input logic [3:0] st, input logic dn, input logic zero, input logic ill);
        ctl_t e;
        e = '0;
        e.state = st;
        e.illegal_op = ill;
        case (st)
            4'd0:  begin e.mem_read = 1'b1; e.alu_src_b = 2'b01; e.ir_write = dn; e.pc_write = dn; end
            4'd1:  e.alu_src_b = 2'b11;
            4'd2:  begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; end
            4'd3:  begin e.mem_read = 1'b1; e.i_or_d = 1'b1; end
            4'd4:  begin e.mem_to_reg = 1'b1; e.reg_write = 1'b1; e.instr_done = 1'b1; end
            4'd5:  begin e.mem_write = 1'b1; e.i_or_d = 1'b1; e.instr_done = dn; end
            4'd6:  begin e.alu_src_a = 1'b1; e.alu_op = 2'b10; end
            4'd7:  begin e.reg_dst = 1'b1; e.reg_write = 1'b1; e.instr_done = 1'b1; end
            4'd8:  begin e.alu_src_a = 1'b1; e.alu_op = 2'b01; e.pc_source = 2'b01;
                         e.pc_write = zero; e.instr_done = 1'b1; end
            4'd9:  begin e.pc_source = 2'b10; e.pc_write = 1'b1; e.instr_done = 1'b1; end
            4'd10: begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; end
            4'd11: begin e.reg_write = 1'b1; e.instr_done = 1'b1; end
            default: e = '0;
        endcase
        return e;
    endfunction

    // Leaves the bench at the negedge of the first FETCH cycle after reset.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; mem_ready = 1'b0; is_zero = 1'b0; opcode = 6'b000000;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        ctl_t e;
        @(negedge clk); #1;
        tests++; if (c0 !== ctl_t'(0)) begin errors++; $display("FAIL reset_hold_lat1 got=%h exp=%h", c0, ctl_t'(0)); end
        tests++; if (c1 !== ctl_t'(0)) begin errors++; $display("FAIL reset_hold_hs got=%h exp=%h", c1, ctl_t'(0)); end
        tests++; if (c2 !== ctl_t'(0)) begin errors++; $display("FAIL reset_hold_lat3 got=%h exp=%h", c2, ctl_t'(0)); end
        @(negedge clk);
        rst = 1'b0; #1;
        e = exp_ctl(4'd0, 1'b1, 1'b0, 1'b0);
        tests++; if (c0 !== e) begin errors++; $display("FAIL reset_release_lat1 got=%h exp=%h", c0, e); end
        e = exp_ctl(4'd0, 1'b0, 1'b0, 1'b0);
        tests++; if (c1 !== e) begin errors++; $display("FAIL reset_release_hs got=%h exp=%h", c1, e); end
        tests++; if (c2 !== e) begin errors++; $display("FAIL reset_release_lat3 got=%h exp=%h", c2, e); end
    endtask

    task automatic test_lw();
        logic [3:0] seq [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
        ctl_t e;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            opcode = 6'b100011; #1;
            e = exp_ctl(seq[i], 1'b1, 1'b0, 1'b0);
            tests++; if (c0 !== e) begin errors++; $display("FAIL lw cyc%0d got=%h exp=%h", i, c0, e); end
        end
    endtask

    task automatic test_branch();
        logic [3:0] seq  [7] = '{4'd0, 4'd1, 4'd8, 4'd0, 4'd1, 4'd8, 4'd0};
        logic       zero [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        ctl_t e;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            if (i > 0) @(negedge clk);
            opcode = 6'b000100; is_zero = zero[i]; #1;
            e = exp_ctl(seq[i], 1'b1, zero[i], 1'b0);
            tests++; if (c0 !== e) begin errors++; $display("FAIL beq cyc%0d got=%h exp=%h", i, c0, e); end
        end
    endtask

    task automatic test_addi_jump_back_to_back();
        logic [3:0] seq [8] = '{4'd0, 4'd1, 4'd10, 4'd11, 4'd0, 4'd1, 4'd9, 4'd0};
        ctl_t e;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            opcode = (i < 4) ? 6'b001000 : 6'b000010; #1;
            e = exp_ctl(seq[i], 1'b1, 1'b0, 1'b0);
            tests++; if (c0 !== e) begin errors++; $display("FAIL addi_j cyc%0d got=%h exp=%h", i, c0, e); end
        end
    endtask

    task automatic test_illegal();
        logic [3:0] seq [7] = '{4'd0, 4'd1, 4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
        logic       ill [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        ctl_t e;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            if (i > 0) @(negedge clk);
            opcode = (i < 2) ? 6'b111111 : 6'b000000; #1;
            e = exp_ctl(seq[i], 1'b1, 1'b0, ill[i]);
            tests++; if (c0 !== e) begin errors++; $display("FAIL illegal cyc%0d got=%h exp=%h", i, c0, e); end
        end
    endtask

    task automatic test_fetch_handshake();
        logic [3:0] seq [10] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd6, 4'd7, 4'd0, 4'd0};
        logic       mr  [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        ctl_t e;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            opcode = 6'b000000; mem_ready = mr[i]; #1;
            e = exp_ctl(seq[i], mr[i], 1'b0, 1'b0);
            tests++; if (c1 !== e) begin errors++; $display("FAIL hs_fetch cyc%0d got=%h exp=%h", i, c1, e); end
        end
        mem_ready = 1'b0;
    endtask

    task automatic test_sw_latency();
        logic [3:0] seq [9] = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd5, 4'd0};
        logic       dn  [9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        ctl_t e;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            if (i > 0) @(negedge clk);
            opcode = 6'b101011; #1;
            e = exp_ctl(seq[i], dn[i], 1'b0, 1'b0);
            tests++; if (c2 !== e) begin errors++; $display("FAIL sw_lat3 cyc%0d got=%h exp=%h", i, c2, e); end
        end
    endtask

    task automatic test_jump_disabled();
        logic [3:0] seq [5] = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd0};
        logic       dn  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic       ill [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        ctl_t e;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            opcode = 6'b000010; #1;
            e = exp_ctl(seq[i], dn[i], 1'b0, ill[i]);
            tests++; if (c2 !== e) begin errors++; $display("FAIL j_disabled cyc%0d got=%h exp=%h", i, c2, e); end
        end
    endtask

    // Continues from the FETCH left by test_jump_disabled, so illegal_op is already set.
    task automatic test_reset_mid_write();
        logic [3:0] seq [6] = '{4'd0, 4'd0, 4'd1, 4'd2, 4'd5, 4'd5};
        logic       dn  [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        ctl_t e;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            opcode = 6'b101011; #1;
            e = exp_ctl(seq[i], dn[i], 1'b0, 1'b1);
            tests++; if (c2 !== e) begin errors++; $display("FAIL rst_mid_pre cyc%0d got=%h exp=%h", i, c2, e); end
        end
        @(negedge clk);
        rst = 1'b1; #1;
        tests++; if (c2 !== ctl_t'(0)) begin errors++; $display("FAIL rst_mid_kill got=%h exp=%h", c2, ctl_t'(0)); end
        @(negedge clk);
        rst = 1'b0; #1;
        e = exp_ctl(4'd0, 1'b0, 1'b0, 1'b0);
        tests++; if (c2 !== e) begin errors++; $display("FAIL rst_mid_after got=%h exp=%h", c2, e); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        tests = 0; errors = 0;
        rst = 1'b1; opcode = 6'b000000; is_zero = 1'b0; mem_ready = 1'b0;
        test_reset();
        test_lw();
        test_branch();
        test_addi_jump_back_to_back();
        test_illegal();
        test_fetch_handshake();
        test_sw_latency();
        test_jump_disabled();
        test_reset_mid_write();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_control.md
# mips_multicycle_control

Parametrised multi-cycle control unit for the next-generation MIPS-32 core. It replaces the single-cycle opcode decoder and branch AND gate with a state machine. The FSM sequences one instruction over several clock cycles through a shared ALU and a unified instruction/data memory. Memory states stall on a configurable wait mechanism, so slow or handshaked memories can be attached.

## Interface
Parameters:
- MEM_HANDSHAKE, 1, 1: memory states end on mem_ready; 0: memory states end after a fixed MEM_LATENCY cycles.
- MEM_LATENCY, 1, cycles per memory state when MEM_HANDSHAKE=0; legal range ≥1.
- ENABLE_ADDI, 1, 1 decodes addi (001000); 0 treats it as illegal.
- ENABLE_JUMP, 1, 1 decodes j (000010); 0 treats it as illegal.

Ports:
- globalclock  in  1  single clock; all state updates on rising edge.
- globalreset  in  1  synchronous, active-high reset.
- opcode  in  6  instruction register bits [31:26]; sampled in DECODE only.
- is_zero  in  1  ALU zero flag; used in BRANCH only.
- mem_ready  in  1  memory completion strobe; ignored outside memory states and when MEM_HANDSHAKE=0.
- pc_write  out  1  PC load enable.
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  instruction register load enable.
- reg_dst  out  1  write register select: 0 = rt, 1 = rd.
- mem_to_reg  out  1  write data select: 0 = ALUOut, 1 = MDR.
- reg_write  out  1  register file write enable.
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = register A.
- alu_src_b  out  2  ALU B select: 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = shifted sign-extended immediate.
- alu_op  out  2  to the ALU control unit: 00 = add, 01 = sub, 10 = funct.
- pc_source  out  2  next-PC select: 00 = ALU, 01 = ALUOut, 10 = jump target.
- instr_done  out  1  one-cycle pulse on the last cycle of each legal instruction.
- illegal_op  out  1  sticky flag, set on an undecodable opcode.
- state  out  4  current state encoding, for debug.

## Operation
- State encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9, ADDI_EXEC=10, ADDI_WB=11. Codes 12–15 are unused and return to FETCH on the next edge.
- All outputs are combinational decodes of `state` (plus `done`, `is_zero`, `opcode`). Any output not listed for a state is 0.
- FETCH drives mem_read=1, alu_src_b=01, and alu_op=00. It drives ir_write and pc_write equal to `done`. It moves to DECODE when done.
- DECODE drives alu_src_b=11 and alu_op=00 (branch target precompute). Next state by opcode:
  - 000000 → R_EXEC
  - 100011 or 101011 → MEM_ADDR
  - 000100 → BRANCH
  - 000010 → JUMP
  - 001000 → ADDI_EXEC
  - anything else → FETCH, with illegal_op set
- MEM_ADDR drives alu_src_a=1, alu_src_b=10, alu_op=00. It goes to MEM_READ for lw and to MEM_WRITE for sw.
- MEM_READ drives mem_read=1 and i_or_d=1. It goes to MEM_WB when done.
- MEM_WB drives mem_to_reg=1 and reg_write=1, then goes to FETCH.
- MEM_WRITE drives mem_write=1 and i_or_d=1. It goes to FETCH when done.
- R_EXEC drives alu_src_a=1, alu_src_b=00, alu_op=10, then goes to R_WB.
- R_WB drives reg_dst=1 and reg_write=1, then goes to FETCH.
- BRANCH drives alu_src_a=1, alu_op=01, pc_source=01, and pc_write=is_zero, then goes to FETCH.
- JUMP drives pc_source=10 and pc_write=1, then goes to FETCH.
- ADDI_EXEC drives alu_src_a=1, alu_src_b=10, alu_op=00, then goes to ADDI_WB.
- ADDI_WB drives reg_write=1 with reg_dst=0 and mem_to_reg=0, then goes to FETCH.
- instr_done is 1 in MEM_WB, in MEM_WRITE when done, and in R_WB, BRANCH, JUMP and ADDI_WB.
- An opcode disabled by its ENABLE_* parameter is illegal.
- illegal_op stays set until reset; it does not halt the FSM.

## Timing
- `done` applies in the memory states (FETCH, MEM_READ, MEM_WRITE):
  - MEM_HANDSHAKE=1: done = mem_ready.
  - MEM_HANDSHAKE=0: done = (wait_cnt == MEM_LATENCY-1).
- wait_cnt is $clog2(MEM_LATENCY+1) bits wide. It increments each cycle in a memory state while not done. It clears to 0 on the cycle done is high and whenever the FSM is outside a memory state.
- All outputs hold stable for every wait cycle of a memory state.
- Cycle counts with zero wait (MEM_LATENCY=1, or mem_ready constantly 1):
  - lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- Each memory state adds its wait cycles on top of these counts.
- Reset, asserted on any cycle:
  - All outputs are forced to 0 combinationally while globalreset is high, including any in-flight mem_write or reg_write.
  - At the next edge, state becomes FETCH, and wait_cnt and illegal_op clear.
  - The first cycle after release is FETCH, with mem_read=1.
- A mem_ready pulse outside a memory state is ignored. It does not carry over into the next memory state.

## Test plan
- lw after reset, MEM_HANDSHAKE=0, MEM_LATENCY=1 → states 0,1,2,3,4. reg_write=1 and mem_to_reg=1 appear only in cycle 5; instr_done pulses once.
- beq with is_zero=1, then beq with is_zero=0 → BRANCH has pc_write=1 and pc_source=01 in the first case, pc_write=0 in the second. Each instruction takes 3 cycles.
- MEM_HANDSHAKE=1, mem_ready held low 4 cycles in FETCH, then high → FETCH lasts 5 cycles with mem_read=1 throughout. ir_write and pc_write are high only in the 5th cycle.
- MEM_HANDSHAKE=0, MEM_LATENCY=3, sw → MEM_WRITE lasts 3 cycles with mem_write=1 throughout. Total is 8 cycles (FETCH 3, DECODE, MEM_ADDR, MEM_WRITE 3).
- opcode 111111, then ENABLE_JUMP=0 with opcode 000010 → DECODE→FETCH and illegal_op=1, staying 1. No instr_done pulse. The next R-type instruction completes in 4 cycles.
- Reset asserted during MEM_WRITE wait → mem_write drops to 0 the same cycle. state=0 and illegal_op=0 after the edge.
